// File: rtl/cv32e40p_apu_router_pkg.sv
// Shared APU constants and router types.
// The core-side APU widths live here so the core wrapper, the router and the
// accelerators agree on operand, opcode and flag sizes.
package cv32e40p_apu_router_pkg;

   localparam int APU_NARGS_CPU    = 3;
   localparam int APU_WOP_CPU      = 6;
   localparam int APU_NDSFLAGS_CPU = 15;
   localparam int APU_NUSFLAGS_CPU = 5;

   // Largest channel count the router is meant to be built with.
   localparam int APU_ROUTER_MAX_CH = 8;

   // One result record as it travels back towards the core.
   typedef struct packed {
      logic [31:0]                 result;
      logic [APU_NUSFLAGS_CPU-1:0] rflags;
   } apu_rsp_t;

endpackage

// File: rtl/cv32e40p_apu_router_fifo.sv
// Small synchronous FIFO used for the issue-order queue and the per-channel
// response buffers. A push at full is accepted only when a pop happens in the
// same cycle; a pop at empty is ignored (no write-through).
module cv32e40p_apu_router_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cv32e40p_apu_router.sv
// Multi-channel APU dispatcher: routes core requests to the channel named by
// apu_chan_i and returns results to the core strictly in issue order.
// Optional feature macro: CV32E40P_APU_ROUTER_ERR_RSP_EN -- when defined, a
// request to a non-existent channel is granted and answered with result 0 and
// all-ones flags; when undefined, such a request is simply never granted.
module cv32e40p_apu_router
   import cv32e40p_apu_router_pkg::*;
#(
   parameter int NUM_CHANNELS    = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RSP_DEPTH       = 2,
   parameter int NARGS           = APU_NARGS_CPU,
   parameter int WOP             = APU_WOP_CPU,
   parameter int NDSFLAGS        = APU_NDSFLAGS_CPU,
   parameter int NUSFLAGS        = APU_NUSFLAGS_CPU,
   localparam int CH_W           = $clog2(NUM_CHANNELS + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               apu_req_i,
   input  logic [CH_W-1:0]                    apu_chan_i,
   input  logic [NARGS-1:0][31:0]             apu_operands_i,
   input  logic [WOP-1:0]                     apu_op_i,
   input  logic [NDSFLAGS-1:0]                apu_flags_i,
   output logic                               apu_gnt_o,
   output logic                               apu_rvalid_o,
   output logic [31:0]                        apu_result_o,
   output logic [NUSFLAGS-1:0]                apu_rflags_o,
   output logic [NUM_CHANNELS-1:0]            ch_req_o,
   input  logic [NUM_CHANNELS-1:0]            ch_gnt_i,
   output logic [NARGS-1:0][31:0]             ch_operands_o,
   output logic [WOP-1:0]                     ch_op_o,
   output logic [NDSFLAGS-1:0]                ch_flags_o,
   input  logic [NUM_CHANNELS-1:0]            ch_rvalid_i,
   input  logic [NUM_CHANNELS-1:0][31:0]      ch_result_i,
   input  logic [NUM_CHANNELS-1:0][NUSFLAGS-1:0] ch_rflags_i
);

   localparam int CR_W  = $clog2(RSP_DEPTH + 1);
   localparam int RSP_W = 32 + NUSFLAGS;

   logic [CR_W-1:0]         credit [NUM_CHANNELS];
   logic                    can_issue;
   logic                    issue;
   logic [NUM_CHANNELS-1:0] grant_vec;
   logic [CH_W-1:0]         ord_push_data;
   logic [CH_W-1:0]         ord_head;
   logic                    ord_full;
   logic                    ord_empty;
   logic                    retire;
   logic [NUM_CHANNELS-1:0] retire_vec;
   logic [RSP_W-1:0]        head_data;
   logic [NUM_CHANNELS-1:0] rsp_push;
   logic [NUM_CHANNELS-1:0] rsp_empty;
   logic [NUM_CHANNELS-1:0] rsp_full_unused;
   logic [RSP_W-1:0]        rsp_data [NUM_CHANNELS];

   // Every channel sees the same request fields; only ch_req_o selects one.
   assign ch_operands_o = apu_operands_i;
   assign ch_op_o       = apu_op_i;
   assign ch_flags_o    = apu_flags_i;

   // A slot in the order queue frees up in the same cycle the head retires.
   assign can_issue = ~rst_i & (~ord_full | retire);

   // Issue: steer the request to its channel if both order and credit allow.
   always_comb begin
      ch_req_o      = '0;
      ord_push_data = apu_chan_i;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (apu_req_i && can_issue && apu_chan_i == CH_W'(c) &&
             credit[c] < CR_W'(RSP_DEPTH)) begin
            ch_req_o[c] = 1'b1;
         end
      end
      grant_vec = ch_req_o & ch_gnt_i;
      issue     = |grant_vec;
`ifdef CV32E40P_APU_ROUTER_ERR_RSP_EN
      if (apu_req_i && can_issue && int'(apu_chan_i) >= NUM_CHANNELS) begin
         issue         = 1'b1;
         ord_push_data = CH_W'(NUM_CHANNELS);
      end
`endif
   end

   assign apu_gnt_o = issue;

   // Retire: the oldest request completes once its channel has a result ready.
   always_comb begin
      retire_vec = '0;
      head_data  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (ord_head == CH_W'(c)) begin
            head_data     = rsp_data[c];
            retire_vec[c] = ~ord_empty & ~rsp_empty[c] & ~rst_i;
         end
      end
      retire = |retire_vec;
`ifdef CV32E40P_APU_ROUTER_ERR_RSP_EN
      if (!ord_empty && !rst_i && int'(ord_head) >= NUM_CHANNELS) begin
         retire    = 1'b1;
         head_data = {32'h0, {NUSFLAGS{1'b1}}};
      end
`endif
   end

   assign apu_rvalid_o = retire;
   assign apu_result_o = retire ? head_data[RSP_W-1:NUSFLAGS] : '0;
   assign apu_rflags_o = retire ? head_data[NUSFLAGS-1:0]     : '0;

   // Per-channel in-flight credits: up on grant, down on retire.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CHANNELS; c++) credit[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            credit[c] <= credit[c] + CR_W'(grant_vec[c]) - CR_W'(retire_vec[c]);
         end
      end
   end

   cv32e40p_apu_router_fifo #(
      .WIDTH (CH_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_order_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (issue),
      .wdata (ord_push_data),
      .pop   (retire),
      .rdata (ord_head),
      .full  (ord_full),
      .empty (ord_empty)
   );

   // Responses are only captured for channels with something in flight, so
   // results for requests issued before a reset are discarded.
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rsp
      assign rsp_push[c] = ch_rvalid_i[c] & (credit[c] != '0) & ~rst_i;

      cv32e40p_apu_router_fifo #(
         .WIDTH (RSP_W),
         .DEPTH (RSP_DEPTH)
      ) u_rsp_fifo (
         .clk   (clk_i),
         .rst   (rst_i),
         .push  (rsp_push[c]),
         .wdata ({ch_result_i[c], ch_rflags_i[c]}),
         .pop   (retire_vec[c]),
         .rdata (rsp_data[c]),
         .full  (rsp_full_unused[c]),
         .empty (rsp_empty[c])
      );
   end

endmodule

// File: tb/tb_cv32e40p_apu_router.sv
// Testbench for cv32e40p_apu_router. The accelerators are modelled as fixed
// per-channel latency pipes; expected core-side behaviour comes from an
// in-flight list where each request's retire cycle is the later of
// "its result arrived + 1" and "the previous request retired + 1".
module tb_cv32e40p_apu_router;
   import cv32e40p_apu_router_pkg::*;

   localparam int NCH   = 2;
   localparam int MAXO  = 4;
   localparam int RD    = 2;
   localparam int NARGS = APU_NARGS_CPU;
   localparam int WOP   = APU_WOP_CPU;
   localparam int NDS   = APU_NDSFLAGS_CPU;
   localparam int NUS   = APU_NUSFLAGS_CPU;
   localparam int CH_W  = $clog2(NCH + 1);
`ifdef CV32E40P_APU_ROUTER_ERR_RSP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     apu_req_i;
   logic [CH_W-1:0]          apu_chan_i;
   logic [NARGS-1:0][31:0]   apu_operands_i;
   logic [WOP-1:0]           apu_op_i;
   logic [NDS-1:0]           apu_flags_i;
   logic                     apu_gnt_o;
   logic                     apu_rvalid_o;
   logic [31:0]              apu_result_o;
   logic [NUS-1:0]           apu_rflags_o;
   logic [NCH-1:0]           ch_req_o;
   logic [NCH-1:0]           ch_gnt_i;
   logic [NARGS-1:0][31:0]   ch_operands_o;
   logic [WOP-1:0]           ch_op_o;
   logic [NDS-1:0]           ch_flags_o;
   logic [NCH-1:0]           ch_rvalid_i;
   logic [NCH-1:0][31:0]     ch_result_i;
   logic [NCH-1:0][NUS-1:0]  ch_rflags_i;

   typedef struct {
      int             chan;
      int             retire_at;
      logic [31:0]    result;
      logic [NUS-1:0] flags;
   } item_t;

   typedef struct {
      int             chan;
      int             due;
      logic [31:0]    result;
      logic [NUS-1:0] flags;
   } pend_t;

   item_t       inflight[$];
   pend_t       pend[$];
   int          lat [NCH];
   int          cyc;
   int          checks;
   int          fails;
   int          gnt_count;
   int          rv_count;
   int          last_gnt_cyc;
   int          last_rv_cyc;
   logic [31:0] last_rv_res;

   cv32e40p_apu_router dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .apu_req_i      (apu_req_i),
      .apu_chan_i     (apu_chan_i),
      .apu_operands_i (apu_operands_i),
      .apu_op_i       (apu_op_i),
      .apu_flags_i    (apu_flags_i),
      .apu_gnt_o      (apu_gnt_o),
      .apu_rvalid_o   (apu_rvalid_o),
      .apu_result_o   (apu_result_o),
      .apu_rflags_o   (apu_rflags_o),
      .ch_req_o       (ch_req_o),
      .ch_gnt_i       (ch_gnt_i),
      .ch_operands_o  (ch_operands_o),
      .ch_op_o        (ch_op_o),
      .ch_flags_o     (ch_flags_o),
      .ch_rvalid_i    (ch_rvalid_i),
      .ch_result_i    (ch_result_i),
      .ch_rflags_i    (ch_rflags_i)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input logic exp_gnt, input logic [NCH-1:0] exp_req, input logic exp_rv,
                              input logic [31:0] exp_res, input logic [NUS-1:0] exp_flg);
      checks++;
      assert (apu_gnt_o === exp_gnt) else begin
         fails++;
         $error("[TB] FAIL gnt cyc=%0d observed=%0b expected=%0b", cyc, apu_gnt_o, exp_gnt);
      end
      checks++;
      assert (ch_req_o === exp_req) else begin
         fails++;
         $error("[TB] FAIL ch_req cyc=%0d observed=%b expected=%b", cyc, ch_req_o, exp_req);
      end
      checks++;
      assert (apu_rvalid_o === exp_rv) else begin
         fails++;
         $error("[TB] FAIL rvalid cyc=%0d observed=%0b expected=%0b", cyc, apu_rvalid_o, exp_rv);
      end
      checks++;
      assert (apu_result_o === exp_res) else begin
         fails++;
         $error("[TB] FAIL result cyc=%0d observed=%h expected=%h", cyc, apu_result_o, exp_res);
      end
      checks++;
      assert (apu_rflags_o === exp_flg) else begin
         fails++;
         $error("[TB] FAIL rflags cyc=%0d observed=%h expected=%h", cyc, apu_rflags_o, exp_flg);
      end
      checks++;
      assert (ch_operands_o === apu_operands_i && ch_op_o === apu_op_i && ch_flags_o === apu_flags_i) else begin
         fails++;
         $error("[TB] FAIL broadcast cyc=%0d observed_op=%h expected_op=%h", cyc, ch_op_o, apu_op_i);
      end
      if (apu_gnt_o === 1'b1) begin
         gnt_count++;
         last_gnt_cyc = cyc;
      end
      if (apu_rvalid_o === 1'b1) begin
         rv_count++;
         last_rv_cyc = cyc;
         last_rv_res = apu_result_o;
      end
   endtask

   // One clock cycle: drive inputs, predict and check outputs, advance the model.
   task automatic applyStimulus(input bit rst_v, input bit req_v, input int chan_v,
                                input logic [NCH-1:0] gnt_v, input logic [31:0] res_v);
      logic [CH_W-1:0] chan_t;
      int              chan_e;
      int              occ;
      int              prev_ret;
      int              arrive;
      int              credit [NCH];
      bit              retire_now;
      bit              order_ok;
      logic            exp_gnt;
      logic            exp_rv;
      logic [NCH-1:0]  exp_req;
      logic [31:0]     exp_res;
      logic [NUS-1:0]  exp_flg;
      item_t           it;
      pend_t           pe;
      pend_t           keep[$];

      // The channel field is CH_W bits wide, so e.g. 7 reaches the DUT as 3.
      chan_t = chan_v[CH_W-1:0];
      chan_e = int'(chan_t);

      rst        = rst_v;
      apu_req_i  = req_v;
      apu_chan_i = chan_t;
      for (int a = 0; a < NARGS; a++) apu_operands_i[a] = $urandom;
      apu_op_i    = WOP'($urandom);
      apu_flags_i = NDS'($urandom);
      ch_gnt_i    = gnt_v;
      ch_rvalid_i = '0;
      ch_result_i = '0;
      ch_rflags_i = '0;
      foreach (pend[i]) begin
         if (pend[i].due == cyc) begin
            ch_rvalid_i[pend[i].chan] = 1'b1;
            ch_result_i[pend[i].chan] = pend[i].result;
            ch_rflags_i[pend[i].chan] = pend[i].flags;
         end else begin
            keep.push_back(pend[i]);
         end
      end
      pend = keep;
      #1;

      occ        = inflight.size();
      retire_now = (occ > 0) && (inflight[0].retire_at == cyc);
      order_ok   = (occ < MAXO) || retire_now;
      for (int c = 0; c < NCH; c++) credit[c] = 0;
      foreach (inflight[i]) if (inflight[i].chan < NCH) credit[inflight[i].chan]++;

      exp_req = '0;
      exp_gnt = 1'b0;
      if (!rst_v) begin
         for (int c = 0; c < NCH; c++)
            if (req_v && chan_e == c && order_ok && credit[c] < RD) exp_req[c] = 1'b1;
         exp_gnt = |(exp_req & gnt_v);
         if (ERR_EN && req_v && chan_e >= NCH && order_ok) exp_gnt = 1'b1;
      end
      exp_rv  = !rst_v && retire_now;
      exp_res = exp_rv ? inflight[0].result : 32'h0;
      exp_flg = exp_rv ? inflight[0].flags : '0;

      checkOutput(exp_gnt, exp_req, exp_rv, exp_res, exp_flg);

      if (rst_v) begin
         inflight.delete();
      end else begin
         if (retire_now) void'(inflight.pop_front());
         if (exp_gnt) begin
            prev_ret = (inflight.size() > 0) ? inflight[inflight.size()-1].retire_at : cyc;
            it.chan  = chan_e;
            if (chan_e < NCH) begin
               arrive    = cyc + lat[chan_e];
               it.result = res_v;
               it.flags  = NUS'($urandom);
               pe.chan   = chan_e;
               pe.due    = arrive;
               pe.result = it.result;
               pe.flags  = it.flags;
               pend.push_back(pe);
            end else begin
               arrive    = cyc;
               it.result = 32'h0;
               it.flags  = '1;
            end
            it.retire_at = (arrive + 1 > prev_ret + 1) ? arrive + 1 : prev_ret + 1;
            inflight.push_back(it);
         end
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Idle until every request has retired and every channel has answered.
   task automatic drainAll();
      int n = 0;
      while ((inflight.size() > 0 || pend.size() > 0) && n < 300) begin
         applyStimulus(1'b0, 1'b0, 0, '1, 32'h0);
         n++;
      end
      checkValue("drain_timeout", 32'(inflight.size() + pend.size()), 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      apu_req_i      = 1'b0;
      apu_chan_i     = '0;
      apu_operands_i = '0;
      apu_op_i       = '0;
      apu_flags_i    = '0;
      ch_gnt_i       = '0;
      ch_rvalid_i    = '0;
      ch_result_i    = '0;
      ch_rflags_i    = '0;
      cyc = 0; checks = 0; fails = 0; gnt_count = 0; rv_count = 0;
      last_gnt_cyc = 0; last_rv_cyc = 0; last_rv_res = '0;
      lat[0] = 1; lat[1] = 1;
      @(posedge clk);
      #1;

      $display("[TB] reset with a pending request");
      repeat (3) applyStimulus(1'b1, 1'b1, 0, '1, 32'h0);

      $display("[TB] single request on channel 0, latency 3");
      lat[0] = 3; lat[1] = 3;
      applyStimulus(1'b0, 1'b1, 0, 2'b11, 32'h3F800000);
      drainAll();
      checkValue("single_latency", 32'(last_rv_cyc - last_gnt_cyc), 32'd4);
      checkValue("single_result", last_rv_res, 32'h3F800000);

      $display("[TB] slow channel 0 then fast channel 1");
      lat[0] = 10; lat[1] = 1;
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      drainAll();

      $display("[TB] order queue full");
      lat[0] = 12; lat[1] = 2;
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      repeat (3)  applyStimulus(1'b0, 1'b1, 7, '1, $urandom);
      repeat (16) applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      drainAll();

      $display("[TB] credit limit on channel 1");
      lat[0] = 2; lat[1] = 10;
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      drainAll();

      $display("[TB] reset with three in flight");
      lat[0] = 6; lat[1] = 6;
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      applyStimulus(1'b1, 1'b0, 0, '1, 32'h0);
      rv_count = 0;
      drainAll();
      checkValue("stale_rvalid_count", 32'(rv_count), 32'd0);
      lat[0] = 1; lat[1] = 1;
      gnt_count = 0;
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 0, '1, $urandom);
      applyStimulus(1'b0, 1'b1, 1, '1, $urandom);
      checkValue("post_reset_grants", 32'(gnt_count), 32'd4);
      drainAll();

      $display("[TB] out-of-range channel for 20 cycles");
      gnt_count = 0;
      repeat (20) applyStimulus(1'b0, 1'b1, 7, '1, $urandom);
      checkValue("chan7_grants", 32'(gnt_count), ERR_EN ? 32'd20 : 32'd0);
      drainAll();

      $display("[TB] randomized traffic");
      for (int phase = 0; phase < 5; phase++) begin
         lat[0] = $urandom_range(1, 8);
         lat[1] = $urandom_range(1, 8);
         for (int k = 0; k < 80; k++) begin
            applyStimulus(1'b0, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                          NCH'($urandom), $urandom);
         end
         drainAll();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
